// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling UART receiver with configurable frame format.
//   clk        - system clock, all logic on posedge
//   rst        - asynchronous active-high reset
//   rxd        - raw serial line (idle high), synchronised internally
//   data       - received word, LSB first on the line
//   valid      - a frame is held and not yet consumed
//   ready      - consumer accepts the held word when valid && ready
//   parity_err - parity mismatch on the held frame (0 when PARITY=0)
//   frame_err  - a stop bit of the held frame sampled low
//   overrun    - sticky: a completed frame was dropped while valid was high
module uart_rx_framed #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CNT_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W   = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int SMP_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic             STP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state, state_n;
    logic                    rxd_meta, rxd_s;
    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic [SMP_W-1:0]        samp, samp_n;
    logic [BIT_W-1:0]        bit_idx, bit_n;
    logic                    stop_idx, stop_n;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_bad, fr_bad, armed;
    logic                    frame_start, do_shift, do_par, do_stop, done;
    logic                    fr_now;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                       div_cnt <= div_cnt + DIV_W'(1);
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            samp     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_n;
            samp     <= samp_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
        end
    end

    always_comb begin
        state_n     = state;
        samp_n      = samp;
        bit_n       = bit_idx;
        stop_n      = stop_idx;
        frame_start = 1'b0;
        do_shift    = 1'b0;
        do_par      = 1'b0;
        do_stop     = 1'b0;
        done        = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (armed && !rxd_s) begin
                        state_n     = S_START;
                        samp_n      = '0;
                        frame_start = 1'b1;
                    end
                end
                S_START: begin
                    if (samp == SMP_MID) begin
                        samp_n  = '0;
                        bit_n   = '0;
                        // A start bit that is high again at its centre was noise.
                        state_n = rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        samp_n = samp + SMP_W'(1);
                    end
                end
                S_DATA: begin
                    samp_n = (samp == SMP_LAST) ? '0 : samp + SMP_W'(1);
                    if (samp == SMP_LAST) begin
                        do_shift = 1'b1;
                        if (bit_idx == BIT_LAST) begin
                            bit_n   = '0;
                            stop_n  = 1'b0;
                            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_n = bit_idx + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    samp_n = (samp == SMP_LAST) ? '0 : samp + SMP_W'(1);
                    if (samp == SMP_LAST) begin
                        do_par  = 1'b1;
                        stop_n  = 1'b0;
                        state_n = S_STOP;
                    end
                end
                S_STOP: begin
                    samp_n = (samp == SMP_LAST) ? '0 : samp + SMP_W'(1);
                    if (samp == SMP_LAST) begin
                        do_stop = 1'b1;
                        if (stop_idx == STP_LAST) begin
                            // Finish at mid-stop so a back-to-back start edge is not missed.
                            done    = 1'b1;
                            samp_n  = '0;
                            stop_n  = 1'b0;
                            state_n = S_IDLE;
                        end else begin
                            stop_n = 1'b1;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Final stop sample is folded in directly since fr_bad only updates after this edge.
    assign fr_now = fr_bad | ~rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            par_bad <= 1'b0;
            fr_bad  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            if (frame_start) begin
                par_bad <= 1'b0;
                fr_bad  <= 1'b0;
            end
            if (do_shift)
                shreg <= {rxd_s, shreg[DATA_WIDTH-1:1]};
            if (do_par)
                par_bad <= (PARITY == 1) ? ~(^shreg ^ rxd_s) : (^shreg ^ rxd_s);
            if (do_stop && !rxd_s)
                fr_bad <= 1'b1;
            // After a framing error (e.g. break) wait for the line to go high before re-arming.
            if (done && fr_now)
                armed <= 1'b0;
            else if (tick && rxd_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done && (!valid || ready)) begin
                data       <= shreg;
                parity_err <= (PARITY != 0) && par_bad;
                frame_err  <= fr_now;
                valid      <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (valid && ready)
                overrun <= 1'b0;
            else if (done && valid)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three instances (8N1, 7E1, 8N2) on one clock and
// reset, serial frames driven bit by bit, expected words queued per instance
// and checked by per-instance monitors when each word is handed over.
module tb_uart_rx_framed;

    localparam int BIT = 160;  // clk per bit at 1.6 MHz / 10 kbaud / x16

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic valid_a, valid_b, valid_c;
    logic parity_err_a, parity_err_b, parity_err_c;
    logic frame_err_a, frame_err_b, frame_err_c;
    logic overrun_a, overrun_b, overrun_c;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   got_a = 0, got_b = 0, got_c = 0;
    int   rise_a = 0;
    logic pv_a = 1'b0;
    exp_t q_a[$], q_b[$], q_c[$];
    exp_t ea, eb, ec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                     .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .data(data_a), .valid(valid_a), .ready(ready_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a));

    uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                     .DATA_WIDTH(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .data(data_b), .valid(valid_b), .ready(ready_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b));

    uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                     .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .rxd(rxd_c), .data(data_c), .valid(valid_c), .ready(ready_c),
        .parity_err(parity_err_c), .frame_err(frame_err_c), .overrun(overrun_c));

    // Monitors: a word is consumed on each posedge following valid && ready here.
    always @(negedge clk) begin
        if (valid_a && !pv_a) rise_a = cyc;
        pv_a = valid_a;
        if (!rst && valid_a && ready_a) begin
            n_cmp++;
            got_a++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL mon_a unexpected word data=%h pe=%b fe=%b", data_a, parity_err_a, frame_err_a);
            end else begin
                ea = q_a.pop_front();
                if ({data_a, parity_err_a, frame_err_a} !== {ea.d[7:0], ea.pe, ea.fe}) begin
                    n_err++;
                    $display("FAIL mon_a word got=%h/%b/%b want=%h/%b/%b",
                             data_a, parity_err_a, frame_err_a, ea.d[7:0], ea.pe, ea.fe);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b && ready_b) begin
            n_cmp++;
            got_b++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL mon_b unexpected word data=%h pe=%b fe=%b", data_b, parity_err_b, frame_err_b);
            end else begin
                eb = q_b.pop_front();
                if ({data_b, parity_err_b, frame_err_b} !== {eb.d[6:0], eb.pe, eb.fe}) begin
                    n_err++;
                    $display("FAIL mon_b word got=%h/%b/%b want=%h/%b/%b",
                             data_b, parity_err_b, frame_err_b, eb.d[6:0], eb.pe, eb.fe);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_c && ready_c) begin
            n_cmp++;
            got_c++;
            if (q_c.size() == 0) begin
                n_err++;
                $display("FAIL mon_c unexpected word data=%h pe=%b fe=%b", data_c, parity_err_c, frame_err_c);
            end else begin
                ec = q_c.pop_front();
                if ({data_c, parity_err_c, frame_err_c} !== {ec.d[7:0], ec.pe, ec.fe}) begin
                    n_err++;
                    $display("FAIL mon_c word got=%h/%b/%b want=%h/%b/%b",
                             data_c, parity_err_c, frame_err_c, ec.d[7:0], ec.pe, ec.fe);
                end
            end
        end
    end

    // Drive one bit time; lines only change 1 time unit after a posedge.
    task automatic tx_bit(input int which, input logic b);
        case (which)
            0:       rxd_a = b;
            1:       rxd_b = b;
            default: rxd_c = b;
        endcase
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int which, input logic b, input int nbits);
        for (int i = 0; i < nbits; i++) tx_bit(which, b);
    endtask

    task automatic send(input int which, input logic [8:0] d, input int nb, input bit has_par,
                        input logic pbit, input int nstop, input logic [1:0] stopv);
        tx_bit(which, 1'b0);
        for (int i = 0; i < nb; i++) tx_bit(which, d[i]);
        if (has_par) tx_bit(which, pbit);
        for (int i = 0; i < nstop; i++) tx_bit(which, stopv[i]);
    endtask

    task automatic push(input int which, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        case (which)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic test_reset;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({data_a, valid_a, parity_err_a, frame_err_a, overrun_a} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_a got=%h want=000", {data_a, valid_a, parity_err_a, frame_err_a, overrun_a});
        end
        n_cmp++;
        if ({data_b, valid_b, parity_err_b, frame_err_b, overrun_b} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_b got=%h want=000", {data_b, valid_b, parity_err_b, frame_err_b, overrun_b});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({data_c, valid_c, parity_err_c, frame_err_c, overrun_c} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_c got=%h want=000", {data_c, valid_c, parity_err_c, frame_err_c, overrun_c});
        end
        hold(0, 1'b1, 2);
    endtask

    task automatic test_basic;
        int t0, g0, lat;
        g0 = got_a;
        push(0, 9'h0A5, 1'b0, 1'b0);
        t0 = cyc;
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b01);
        hold(0, 1'b1, 1);
        n_cmp++;
        if (got_a != g0 + 1 || q_a.size() != 0) begin
            n_err++;
            $display("FAIL basic_count got=%0d want=1 pending=%0d", got_a - g0, q_a.size());
        end
        lat = rise_a - t0;
        n_cmp++;
        if (lat < BIT * 19 / 2 + 3 - 10 || lat > BIT * 19 / 2 + 3 + 10) begin
            n_err++;
            $display("FAIL basic_latency got=%0d want=%0d+-10", lat, BIT * 19 / 2 + 3);
        end
    endtask

    task automatic test_parity;
        logic [8:0] dv[3]  = '{9'h035, 9'h035, 9'h007};
        logic       inv[3] = '{1'b0, 1'b1, 1'b0};
        int g0;
        logic pb;
        g0 = got_b;
        for (int i = 0; i < 3; i++) begin
            pb = (^dv[i][6:0]) ^ inv[i];  // even parity bit, optionally corrupted
            push(1, dv[i], (^dv[i][6:0]) ^ pb, 1'b0);
            send(1, dv[i], 7, 1'b1, pb, 1, 2'b01);
            hold(1, 1'b1, 1);
        end
        n_cmp++;
        if (got_b != g0 + 3 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL parity_count got=%0d want=3 pending=%0d", got_b - g0, q_b.size());
        end
    endtask

    task automatic test_break;
        int g0;
        g0 = got_a;
        push(0, 9'h000, 1'b0, 1'b1);
        send(0, 9'h000, 8, 1'b0, 1'b0, 1, 2'b00);
        hold(0, 1'b0, 5);
        n_cmp++;
        if (got_a != g0 + 1 || q_a.size() != 0) begin
            n_err++;
            $display("FAIL break_once got=%0d want=1 pending=%0d", got_a - g0, q_a.size());
        end
        hold(0, 1'b1, 2);
        n_cmp++;
        if (got_a != g0 + 1) begin
            n_err++;
            $display("FAIL break_release got=%0d want=1", got_a - g0);
        end
        push(0, 9'h05A, 1'b0, 1'b0);
        send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b01);
        hold(0, 1'b1, 1);
        n_cmp++;
        if (got_a != g0 + 2 || q_a.size() != 0) begin
            n_err++;
            $display("FAIL break_recover got=%0d want=2 pending=%0d", got_a - g0, q_a.size());
        end
    endtask

    task automatic test_glitch;
        int g0;
        g0 = got_a;
        rxd_a = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        hold(0, 1'b1, 2);
        n_cmp++;
        if (got_a != g0 || valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_reject got=%0d valid=%b want=0/0", got_a - g0, valid_a);
        end
        push(0, 9'h03C, 1'b0, 1'b0);
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b01);
        hold(0, 1'b1, 1);
        n_cmp++;
        if (got_a != g0 + 1 || q_a.size() != 0) begin
            n_err++;
            $display("FAIL glitch_next got=%0d want=1 pending=%0d", got_a - g0, q_a.size());
        end
    endtask

    task automatic test_overrun;
        int g0;
        g0 = got_a;
        ready_a = 1'b0;
        push(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b01);
        hold(0, 1'b1, 1);
        n_cmp++;
        if ({valid_a, data_a, overrun_a} !== {1'b1, 8'h11, 1'b0}) begin
            n_err++;
            $display("FAIL ovr_held got=%b/%h/%b want=1/11/0", valid_a, data_a, overrun_a);
        end
        send(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b01);
        hold(0, 1'b1, 1);
        n_cmp++;
        if ({valid_a, data_a, overrun_a} !== {1'b1, 8'h11, 1'b1}) begin
            n_err++;
            $display("FAIL ovr_discard got=%b/%h/%b want=1/11/1", valid_a, data_a, overrun_a);
        end
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;
        n_cmp++;
        if ({valid_a, overrun_a} !== 2'b00 || got_a != g0 + 1) begin
            n_err++;
            $display("FAIL ovr_clear got=%b/%b cnt=%0d want=0/0 cnt=1", valid_a, overrun_a, got_a - g0);
        end
        ready_a = 1'b1;
        push(0, 9'h033, 1'b0, 1'b0);
        send(0, 9'h033, 8, 1'b0, 1'b0, 1, 2'b01);
        hold(0, 1'b1, 1);
        n_cmp++;
        if (got_a != g0 + 2 || q_a.size() != 0 || overrun_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_next got=%0d ovr=%b pending=%0d want=2/0/0", got_a - g0, overrun_a, q_a.size());
        end
    endtask

    task automatic test_stop2_reset;
        int g0;
        g0 = got_c;
        hold(2, 1'b1, 2);
        // second stop bit low is a framing error even though the first was high
        push(2, 9'h081, 1'b0, 1'b1);
        send(2, 9'h081, 8, 1'b0, 1'b0, 2, 2'b01);
        hold(2, 1'b1, 2);
        n_cmp++;
        if (got_c != g0 + 1 || q_c.size() != 0 || data_c !== 8'h81 || frame_err_c !== 1'b1) begin
            n_err++;
            $display("FAIL stop2_ferr cnt=%0d data=%h fe=%b want=1/81/1", got_c - g0, data_c, frame_err_c);
        end
        // abort a frame in the middle of data bit 4
        tx_bit(2, 1'b0);
        for (int i = 0; i < 4; i++) tx_bit(2, i[0] ? 1'b0 : 1'b1);
        rxd_c = 1'b0;
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({data_c, valid_c, parity_err_c, frame_err_c, overrun_c} !== 12'h000) begin
            n_err++;
            $display("FAIL rst_mid got=%h want=000", {data_c, valid_c, parity_err_c, frame_err_c, overrun_c});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rxd_c = 1'b1;
        hold(2, 1'b1, 4);
        n_cmp++;
        if (got_c != g0 + 1 || valid_c !== 1'b0) begin
            n_err++;
            $display("FAIL rst_partial cnt=%0d valid=%b want=1/0", got_c - g0, valid_c);
        end
        push(2, 9'h07E, 1'b0, 1'b0);
        send(2, 9'h07E, 8, 1'b0, 1'b0, 2, 2'b11);
        hold(2, 1'b1, 1);
        n_cmp++;
        if (got_c != g0 + 2 || q_c.size() != 0) begin
            n_err++;
            $display("FAIL rst_recover cnt=%0d want=2 pending=%0d", got_c - g0, q_c.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_stop2_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
